countdown_screen: RTL and testbench
===================================

Name: countdown_screen

Overview:
- Parametrised pipeline stage on the VGA timing bus; draws a large seven-segment style countdown digit (START_DIGIT down to 1) over a background colour.
- Timed in video frames. At the end of the count it asserts done and passes upstream rgb_in through.
- Timing signals are delayed by one pclk so they stay aligned with rgb_out.

Parameters:
- DIGIT_X, 300: left pixel column of the glyph.
- DIGIT_Y, 150: top pixel row of the glyph.
- CELL, 50: glyph cell size in pixels. The glyph is a 3x5 cell grid, 3*CELL wide and 5*CELL tall.
- FG_COLOR, 12'h22F: digit colour.
- BG_COLOR, 12'h888: background colour while counting or idle.
- FRAMES_PER_DIGIT, 60: frames each digit is shown. Legal range 1..1023.
- START_DIGIT, 3: first digit shown. Legal range 1..9.

Ports:
- pclk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- hcount_in  in  11  horizontal pixel counter
- hsync_in  in  1  horizontal sync
- hblnk_in  in  1  horizontal blanking
- vcount_in  in  11  vertical line counter
- vsync_in  in  1  vertical sync
- vblnk_in  in  1  vertical blanking
- rgb_in  in  12  upstream pixel colour, shown after the countdown
- start  in  1  one-cycle request to begin or restart the countdown
- hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  11/1/1/11/1/1  matching inputs delayed by 1 pclk
- rgb_out  out  12  pixel colour, registered
- digit_out  out  4  digit currently displayed, registered
- busy  out  1  high while in COUNT
- done  out  1  one-cycle pulse when the countdown ends

Behaviour:
- Reset (synchronous, active-high) has priority over all other inputs:
  - All timing outputs and rgb_out go to 0.
  - digit_out = START_DIGIT, busy = 0, done = 0.
  - State = IDLE, frame counter = 0, vblnk history register = 0.
- Pipeline: every timing output and rgb_out is registered from same-cycle inputs, giving exactly 1 pclk latency. No other delay.
- Frame tick: one cycle, high when vblnk_in = 1 and the registered previous vblnk_in = 0 (rising edge).
- State machine, with transitions evaluated each pclk:
  - IDLE: shows START_DIGIT statically. start = 1 moves to COUNT with frame counter = 0 and digit = START_DIGIT.
  - COUNT: busy = 1. On each frame tick:
    - If frame counter = FRAMES_PER_DIGIT-1, the counter clears and then:
      - if digit > 1, digit decrements;
      - if digit = 1, go to DONE.
    - Otherwise the counter increments.
    - start is ignored in COUNT.
  - DONE: done = 1 on the first cycle in DONE only. Output pixel = rgb_in. start = 1 restarts exactly as from IDLE.
- Simultaneous start and frame tick in IDLE/DONE: the start is taken and that tick is not counted (frame counter = 0 after the edge).
- Glyph geometry:
  - Column 0 covers DIGIT_X <= hcount_in < DIGIT_X+CELL; columns 1 and 2 follow, each CELL wide.
  - Row 0 covers DIGIT_Y <= vcount_in < DIGIT_Y+CELL; rows 1 to 4 follow, each CELL tall.
  - All intervals are half-open.
  - Pixels outside the 3x5 grid are not glyph pixels.
- Segment to cell mapping:
  - a = row 0, all columns.
  - b = column 2, rows 0-2.
  - c = column 2, rows 2-4.
  - d = row 4, all columns.
  - e = column 0, rows 2-4.
  - f = column 0, rows 0-2.
  - g = row 2, all columns.
  - A cell is lit if any segment covering it is on.
- Segment sets per digit:
  - 1 = b,c
  - 2 = a,b,g,e,d
  - 3 = a,b,g,c,d
  - 4 = f,g,b,c
  - 5 = a,f,g,c,d
  - 6 = a,f,g,e,c,d
  - 7 = a,b,c
  - 8 = all segments
  - 9 = a,b,c,d,f,g
- rgb_out next-value priority:
  1. hblnk_in or vblnk_in = 1 gives 0.
  2. State DONE gives rgb_in.
  3. A lit glyph cell gives FG_COLOR.
  4. Otherwise BG_COLOR.
- Digit and state changes take effect from the pclk after the frame tick. The change happens during vertical blanking, so no visible frame mixes two digits.
- Width rules:
  - Glyph bounds are computed in 12 bits so that DIGIT_X+3*CELL cannot overflow.
  - The frame counter is 10 bits.
  - digit_out never leaves 1..START_DIGIT.

Test Plan:
- Reset checks:
  - Hold reset 3 cycles with random inputs -> every timing output = 0, rgb_out = 0, digit_out = 3, busy = 0, done = 0.
  - Assert reset mid-COUNT at digit 2 -> the same values on the next cycle.
- IDLE glyph sampling, default parameters, blanking low:
  - (h=300,v=150) -> 12'h22F.
  - (h=300,v=200) -> 12'h888, since f is off for digit 3.
  - (h=400,v=200) -> 12'h22F.
  - (h=450,v=150) -> 12'h888, outside the half-open bound.
  - (h=349,v=250) -> 12'h22F.
- Latency and blanking:
  - A random stream of timing inputs -> each output equals its input from 1 cycle earlier.
  - hblnk_in = 1 over a lit glyph cell -> rgb_out = 0.
- Countdown with FRAMES_PER_DIGIT=2, START_DIGIT=3:
  - start pulse, then 6 vblnk rising edges -> digit_out goes 3,3,2,2,1,1.
  - The 6th tick gives done = 1 for exactly 1 cycle; busy falls at the same time.
  - rgb_out then follows rgb_in = 12'hABC inside the glyph area.
- Start handling:
  - start during COUNT -> ignored; digit sequence unchanged.
  - start in DONE coinciding with a vblnk rising edge -> COUNT, digit_out = 3, frame counter = 0.
  - After that, 2 more ticks are required before digit_out = 2.
- Digit glyphs with START_DIGIT=9:
  - Sample the centre of all 15 cells for each digit 9..1 -> lit/unlit pattern matches the segment table.

Source files
------------

// File: rtl/countdown_screen.sv
// countdown_screen: VGA pipeline stage that draws a frame-timed seven-segment countdown digit.
module countdown_screen #(
    parameter int          DIGIT_X          = 300,
    parameter int          DIGIT_Y          = 150,
    parameter int          CELL             = 50,
    parameter logic [11:0] FG_COLOR         = 12'h22F,
    parameter logic [11:0] BG_COLOR         = 12'h888,
    parameter int          FRAMES_PER_DIGIT = 60,
    parameter int          START_DIGIT      = 3
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        start,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [3:0]  digit_out,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    localparam logic [11:0] X0 = 12'(DIGIT_X);
    localparam logic [11:0] X1 = 12'(DIGIT_X + CELL);
    localparam logic [11:0] X2 = 12'(DIGIT_X + 2 * CELL);
    localparam logic [11:0] X3 = 12'(DIGIT_X + 3 * CELL);
    localparam logic [11:0] Y0 = 12'(DIGIT_Y);
    localparam logic [11:0] Y1 = 12'(DIGIT_Y + CELL);
    localparam logic [11:0] Y2 = 12'(DIGIT_Y + 2 * CELL);
    localparam logic [11:0] Y3 = 12'(DIGIT_Y + 3 * CELL);
    localparam logic [11:0] Y4 = 12'(DIGIT_Y + 4 * CELL);
    localparam logic [11:0] Y5 = 12'(DIGIT_Y + 5 * CELL);
    localparam logic [3:0]  FIRST = 4'(START_DIGIT);
    localparam logic [9:0]  LAST_FRAME = 10'(FRAMES_PER_DIGIT - 1);
    state_t      state;
    logic [9:0]  frame_cnt;
    logic        vblnk_prev;
    logic        frame_tick;
    logic [11:0] hx, vy;
    logic        in_grid;
    logic [1:0]  col;
    logic [2:0]  row;
    logic [6:0]  seg;
    logic        lit;
    logic [11:0] rgb_next;
    // seg bit order is {a,b,c,d,e,f,g}
    always_comb begin
        seg = 7'b0000000;
        case (digit_out)
            4'd1: seg = 7'b0110000;
            4'd2: seg = 7'b1101101;
            4'd3: seg = 7'b1111001;
            4'd4: seg = 7'b0110011;
            4'd5: seg = 7'b1011011;
            4'd6: seg = 7'b1011111;
            4'd7: seg = 7'b1110000;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
    end
    always_comb begin
        hx = {1'b0, hcount_in};
        vy = {1'b0, vcount_in};
        in_grid = hx >= X0 && hx < X3 && vy >= Y0 && vy < Y5;
        col = hx < X1 ? 2'd0 : hx < X2 ? 2'd1 : 2'd2;
        row = vy < Y1 ? 3'd0 : vy < Y2 ? 3'd1 : vy < Y3 ? 3'd2 : vy < Y4 ? 3'd3 : 3'd4;
        lit = in_grid && ((seg[6] && row == 3'd0) ||
                          (seg[5] && col == 2'd2 && row <= 3'd2) ||
                          (seg[4] && col == 2'd2 && row >= 3'd2) ||
                          (seg[3] && row == 3'd4) ||
                          (seg[2] && col == 2'd0 && row >= 3'd2) ||
                          (seg[1] && col == 2'd0 && row <= 3'd2) ||
                          (seg[0] && row == 3'd2));
        rgb_next = (hblnk_in || vblnk_in) ? 12'h000 : state == DONE ? rgb_in : lit ? FG_COLOR : BG_COLOR;
        frame_tick = vblnk_in && !vblnk_prev;
    end
    always_ff @(posedge pclk) begin
        if (reset) begin
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
            digit_out  <= FIRST;
            busy       <= 1'b0;
            done       <= 1'b0;
            state      <= IDLE;
            frame_cnt  <= '0;
            vblnk_prev <= 1'b0;
        end else begin
            hcount_out <= hcount_in;
            hsync_out  <= hsync_in;
            hblnk_out  <= hblnk_in;
            vcount_out <= vcount_in;
            vsync_out  <= vsync_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= rgb_next;
            vblnk_prev <= vblnk_in;
            done       <= 1'b0;
            case (state)
                COUNT: begin
                    if (frame_tick) begin
                        if (frame_cnt == LAST_FRAME) begin
                            frame_cnt <= '0;
                            if (digit_out > 4'd1) begin
                                digit_out <= digit_out - 4'd1;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 10'd1;
                        end
                    end
                end
                default: begin
                    // a start coinciding with a frame tick wins and that tick is not counted
                    if (start) begin
                        state     <= COUNT;
                        frame_cnt <= '0;
                        digit_out <= FIRST;
                        busy      <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_countdown_screen.sv
// tb_countdown_screen: scoreboard bench for the countdown overlay; one instance counts from 3, one from 9.
module tb_countdown_screen;
    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic        start = 1'b0, start_b = 1'b0;
    logic [10:0] hcount_a, vcount_a, hcount_b, vcount_b;
    logic        hsync_a, hblnk_a, vsync_a, vblnk_a, hsync_b, hblnk_b, vsync_b, vblnk_b;
    logic [11:0] rgb_a, rgb_b;
    logic [3:0]  digit_a, digit_b;
    logic        busy_a, done_a, busy_b, done_b;
    always #5 pclk = ~pclk;
    countdown_screen #(.FRAMES_PER_DIGIT(2), .START_DIGIT(3)) dut_a (
        .pclk(pclk), .reset(reset),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .start(start),
        .hcount_out(hcount_a), .hsync_out(hsync_a), .hblnk_out(hblnk_a),
        .vcount_out(vcount_a), .vsync_out(vsync_a), .vblnk_out(vblnk_a),
        .rgb_out(rgb_a), .digit_out(digit_a), .busy(busy_a), .done(done_a)
    );
    countdown_screen #(.FRAMES_PER_DIGIT(1), .START_DIGIT(9)) dut_b (
        .pclk(pclk), .reset(reset),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .start(start_b),
        .hcount_out(hcount_b), .hsync_out(hsync_b), .hblnk_out(hblnk_b),
        .vcount_out(vcount_b), .vsync_out(vsync_b), .vblnk_out(vblnk_b),
        .rgb_out(rgb_b), .digit_out(digit_b), .busy(busy_b), .done(done_b)
    );
    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t q[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    always @(posedge pclk) cyc <= cyc + 1;
    function automatic logic [31:0] act(input int k);
        case (k)
            0: return {20'd0, rgb_a};
            1: return {28'd0, digit_a};
            2: return {31'd0, busy_a};
            3: return {31'd0, done_a};
            4: return {6'd0, hcount_a, hsync_a, hblnk_a, vcount_a, vsync_a, vblnk_a};
            5: return {20'd0, rgb_b};
            6: return {28'd0, digit_b};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction
    // monitor: outputs are sampled on the falling edge, away from the active edge
    exp_t e;
    always @(negedge pclk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if (e.due != cyc || act(e.kind) !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", e.name, act(e.kind), e.exp, cyc);
            end
        end
    end
    task automatic push(input int k, input logic [31:0] v, input string n);
        q.push_back('{cyc + 1, k, v, n});
    endtask
    task automatic drive(input int h, input int v, input logic hb, input logic vb, input logic [11:0] rgb, input logic st);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
        start     = st;
        start_b   = 1'b0;
    endtask
    task automatic step();
        @(posedge pclk);
        #1;
    endtask
    task automatic randomize_inputs();
        hcount_in = 11'($urandom);
        vcount_in = 11'($urandom);
        {hsync_in, hblnk_in, vsync_in, vblnk_in} = 4'($urandom);
        rgb_in  = 12'($urandom);
        start   = 1'($urandom);
        start_b = 1'($urandom);
    endtask
    task automatic expect_reset(input string n);
        push(4, 32'd0, {n, "_timing"});
        push(0, 32'd0, {n, "_rgb"});
        push(1, 32'd3, {n, "_digit"});
        push(2, 32'd0, {n, "_busy"});
        push(3, 32'd0, {n, "_done"});
    endtask
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction
    function automatic logic cell_lit(input int d, input int r, input int c);
        logic [6:0] s;
        s = seg_of(d);
        return (s[6] && r == 0) || (s[5] && c == 2 && r <= 2) || (s[4] && c == 2 && r >= 2) ||
               (s[3] && r == 4) || (s[2] && c == 0 && r >= 2) || (s[1] && c == 0 && r <= 2) ||
               (s[0] && r == 2);
    endfunction
    int dexp[6] = '{3, 2, 2, 1, 1, 1};
    initial begin
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            expect_reset($sformatf("reset%0d", i));
            step();
        end
        reset = 1'b0;
        drive(300, 150, 0, 0, 12'h123, 0); push(0, 32'h22F, "idle_300_150"); step();
        drive(300, 200, 0, 0, 12'h123, 0); push(0, 32'h888, "idle_300_200"); step();
        drive(400, 200, 0, 0, 12'h123, 0); push(0, 32'h22F, "idle_400_200"); step();
        drive(450, 150, 0, 0, 12'h123, 0); push(0, 32'h888, "idle_450_150"); step();
        drive(349, 250, 0, 0, 12'h123, 0); push(0, 32'h22F, "idle_349_250"); step();
        for (int i = 0; i < 8; i++) begin
            randomize_inputs();
            start = 1'b0;
            start_b = 1'b0;
            push(4, {6'd0, hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in}, $sformatf("latency%0d", i));
            step();
        end
        drive(300, 150, 1, 0, 12'h123, 0); push(0, 32'h0, "hblnk_over_lit"); step();
        drive(300, 150, 0, 1, 12'h123, 0); push(0, 32'h0, "vblnk_over_lit"); step();
        drive(0, 0, 0, 0, 12'h000, 0); step();
        drive(0, 0, 0, 0, 12'h000, 1);
        push(2, 32'd1, "busy_after_start");
        push(1, 32'd3, "digit_after_start");
        step();
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 1, 12'h000, 0);
            push(1, 32'(dexp[k]), $sformatf("digit_tick%0d", k + 1));
            push(3, 32'(k == 5), $sformatf("done_tick%0d", k + 1));
            push(2, 32'(k != 5), $sformatf("busy_tick%0d", k + 1));
            step();
            drive(0, 0, 0, 0, 12'h000, k == 2);
            push(1, 32'(dexp[k]), $sformatf("digit_hold%0d", k + 1));
            push(3, 32'd0, $sformatf("done_hold%0d", k + 1));
            step();
        end
        drive(300, 150, 0, 0, 12'hABC, 0); push(0, 32'hABC, "done_pass_lit"); step();
        drive(300, 200, 0, 0, 12'hABC, 0); push(0, 32'hABC, "done_pass_unlit"); step();
        drive(300, 150, 1, 0, 12'hABC, 0); push(0, 32'h0, "done_hblnk"); step();
        drive(0, 0, 0, 1, 12'h000, 1);
        push(2, 32'd1, "restart_busy");
        push(1, 32'd3, "restart_digit");
        push(3, 32'd0, "restart_done");
        step();
        drive(0, 0, 0, 0, 12'h000, 0); step();
        drive(0, 0, 0, 1, 12'h000, 0); push(1, 32'd3, "restart_tick1"); step();
        drive(0, 0, 0, 0, 12'h000, 0); step();
        drive(0, 0, 0, 1, 12'h000, 0); push(1, 32'd2, "restart_tick2"); step();
        drive(0, 0, 0, 0, 12'h000, 0); step();
        reset = 1'b1;
        randomize_inputs();
        expect_reset("reset_mid_count");
        step();
        reset = 1'b0;
        drive(0, 0, 0, 0, 12'h000, 0); step();
        drive(0, 0, 0, 0, 12'h000, 0);
        start_b = 1'b1;
        step();
        for (int d = 9; d >= 1; d--) begin
            drive(0, 0, 0, 0, 12'h000, 0);
            push(6, 32'(d), $sformatf("b_digit%0d", d));
            step();
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 3; c++) begin
                    drive(325 + c * 50, 175 + r * 50, 0, 0, 12'h000, 0);
                    push(5, cell_lit(d, r, c) ? 32'h22F : 32'h888, $sformatf("glyph_d%0d_r%0d_c%0d", d, r, c));
                    step();
                end
            end
            drive(0, 0, 0, 1, 12'h000, 0); step();
            drive(0, 0, 0, 0, 12'h000, 0); step();
        end
        step();
        step();
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
